matmul_feeder: RTL

- Transmit side of the systolic operand interface into matmul_calc.
- Latches full A and B operand matrices on start, then drives per-cycle diagonally skewed A-row and B-column vectors on a_flat_o and b_flat_o.
- Appends zero-flush cycles, then holds start_operation high until the result is collected.
- Replaces the hand-written skew/flush sequencing in benches; sits between the operand register file and matmul_calc.

---
 rtl/matmul_feeder_if.sv | 42 ++++
 rtl/matmul_feeder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/matmul_feeder_if.sv
// Operand-request / skewed-vector bundle between the controller (master) and matmul_feeder (slave).
// The optional dimension fields exist only when MATMUL_FEEDER_DIM_EN is defined.
interface matmul_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 32
);
  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int MAT_W   = DATA_WIDTH * MAX_DIM * MAX_DIM;
  localparam int VEC_W   = DATA_WIDTH * MAX_DIM;
  localparam int DIM_W   = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;

  logic             start_i;
  logic [MAT_W-1:0] a_mat_flat_i;
  logic [MAT_W-1:0] b_mat_flat_i;
  logic             clear_i;
`ifdef MATMUL_FEEDER_DIM_EN
  logic [DIM_W-1:0] dim_n_i;
  logic [DIM_W-1:0] dim_k_i;
  logic [DIM_W-1:0] dim_m_i;
`endif
  logic [VEC_W-1:0] a_flat_o;
  logic [VEC_W-1:0] b_flat_o;
  logic             start_operation_o;
  logic             busy_o;
  logic             done_o;

  modport master (
`ifdef MATMUL_FEEDER_DIM_EN
    output dim_n_i, dim_k_i, dim_m_i,
`endif
    output start_i, a_mat_flat_i, b_mat_flat_i, clear_i,
    input  a_flat_o, b_flat_o, start_operation_o, busy_o, done_o
  );

  modport slave (
`ifdef MATMUL_FEEDER_DIM_EN
    input  dim_n_i, dim_k_i, dim_m_i,
`endif
    input  start_i, a_mat_flat_i, b_mat_flat_i, clear_i,
    output a_flat_o, b_flat_o, start_operation_o, busy_o, done_o
  );
endinterface

// File: rtl/matmul_feeder.sv
// Latches A/B on start and streams diagonally skewed operand vectors, zero flush, then holds done until clear_i.
// First vector one cycle after start; done 3*MAX_DIM-1 edges after start; start_i ignored while busy. Option: MATMUL_FEEDER_DIM_EN.
module matmul_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 32
) (
  input logic            clk_i,
  input logic            rst_n_i,
  matmul_feeder_if.slave bus
);
  localparam int MAX_DIM      = BUS_WIDTH / DATA_WIDTH;
  localparam int ARRAY_LENGTH = 2 * MAX_DIM - 1;
  localparam int CNT_W        = $clog2(ARRAY_LENGTH + MAX_DIM) + 1;
  localparam int MAT_W        = DATA_WIDTH * MAX_DIM * MAX_DIM;
  localparam int VEC_W        = DATA_WIDTH * MAX_DIM;
  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(ARRAY_LENGTH - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(ARRAY_LENGTH + MAX_DIM - 1);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_HOLD} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [MAT_W-1:0] r_a_mat, r_b_mat, w_a_mat_nxt, w_b_mat_nxt;
  logic [VEC_W-1:0] r_a_vec, r_b_vec, w_a_vec_nxt, w_b_vec_nxt;
  logic             r_start_op, r_busy, r_done;
  logic             w_start_op_nxt, w_busy_nxt, w_done_nxt;

  logic [MAT_W-1:0] w_src_a, w_src_b;
  logic [CNT_W-1:0] w_vec_idx;
  logic [VEC_W-1:0] w_a_skew, w_b_skew;

`ifdef MATMUL_FEEDER_DIM_EN
  localparam int DIM_W = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  logic [DIM_W-1:0] r_dim_n, r_dim_k, r_dim_m;
  logic [DIM_W-1:0] w_dim_n, w_dim_k, w_dim_m;

  // In IDLE the start-edge vector is built straight from the inputs being latched.
  assign w_dim_n = (r_state == S_IDLE) ? bus.dim_n_i : r_dim_n;
  assign w_dim_k = (r_state == S_IDLE) ? bus.dim_k_i : r_dim_k;
  assign w_dim_m = (r_state == S_IDLE) ? bus.dim_m_i : r_dim_m;
`endif

  assign w_src_a   = (r_state == S_IDLE) ? bus.a_mat_flat_i : r_a_mat;
  assign w_src_b   = (r_state == S_IDLE) ? bus.b_mat_flat_i : r_b_mat;
  assign w_vec_idx = (r_state == S_IDLE) ? '0 : r_cnt + 1'b1;

  // Lane i on cycle c carries the k = c-i diagonal element.
  always_comb begin
    w_a_skew = '0;
    w_b_skew = '0;
    for (int i = 0; i < MAX_DIM; i++) begin
      for (int k = 0; k < MAX_DIM; k++) begin
        if (int'(w_vec_idx) == i + k) begin
`ifdef MATMUL_FEEDER_DIM_EN
          if (i <= int'(w_dim_n) && k <= int'(w_dim_k))
`endif
            w_a_skew[i*DATA_WIDTH +: DATA_WIDTH] = w_src_a[(i*MAX_DIM+k)*DATA_WIDTH +: DATA_WIDTH];
`ifdef MATMUL_FEEDER_DIM_EN
          if (k <= int'(w_dim_k) && i <= int'(w_dim_m))
`endif
            w_b_skew[i*DATA_WIDTH +: DATA_WIDTH] = w_src_b[(k*MAX_DIM+i)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_a_mat_nxt    = r_a_mat;
    w_b_mat_nxt    = r_b_mat;
    w_a_vec_nxt    = '0;
    w_b_vec_nxt    = '0;
    w_start_op_nxt = r_start_op;
    w_busy_nxt     = r_busy;
    w_done_nxt     = r_done;
    case (r_state)
      S_IDLE: begin
        w_start_op_nxt = 1'b0;
        w_busy_nxt     = 1'b0;
        w_done_nxt     = 1'b0;
        if (bus.start_i) begin
          w_state_nxt    = S_FEED;
          w_cnt_nxt      = '0;
          w_a_mat_nxt    = bus.a_mat_flat_i;
          w_b_mat_nxt    = bus.b_mat_flat_i;
          w_a_vec_nxt    = w_a_skew;
          w_b_vec_nxt    = w_b_skew;
          w_start_op_nxt = 1'b1;
          w_busy_nxt     = 1'b1;
        end
      end
      S_FEED: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == FEED_LAST) begin
          w_state_nxt = S_FLUSH;
        end else begin
          w_a_vec_nxt = w_a_skew;
          w_b_vec_nxt = w_b_skew;
        end
      end
      S_FLUSH: begin
        // The counter keeps running from FEED, so the flush ends at a fixed absolute count.
        if (r_cnt == FLUSH_LAST) begin
          w_state_nxt = S_HOLD;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.clear_i) begin
          w_state_nxt    = S_IDLE;
          w_cnt_nxt      = '0;
          w_start_op_nxt = 1'b0;
          w_busy_nxt     = 1'b0;
          w_done_nxt     = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_a_mat    <= '0;
      r_b_mat    <= '0;
      r_a_vec    <= '0;
      r_b_vec    <= '0;
      r_start_op <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_a_mat    <= w_a_mat_nxt;
      r_b_mat    <= w_b_mat_nxt;
      r_a_vec    <= w_a_vec_nxt;
      r_b_vec    <= w_b_vec_nxt;
      r_start_op <= w_start_op_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

`ifdef MATMUL_FEEDER_DIM_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_dim_n <= '0;
      r_dim_k <= '0;
      r_dim_m <= '0;
    end else if (r_state == S_IDLE && bus.start_i) begin
      r_dim_n <= bus.dim_n_i;
      r_dim_k <= bus.dim_k_i;
      r_dim_m <= bus.dim_m_i;
    end
  end
`endif

  assign bus.a_flat_o          = r_a_vec;
  assign bus.b_flat_o          = r_b_vec;
  assign bus.start_operation_o = r_start_op;
  assign bus.busy_o            = r_busy;
  assign bus.done_o            = r_done;
endmodule
